// File: rtl/garo_trng_core_pkg.sv
// Shared state encoding and parameter range limits for the GARO TRNG core.
package garo_trng_core_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAIL   = 2'd3
  } garo_state_e;

  localparam int MAX_STAGES    = 63;
  localparam int MAX_RCT_LIMIT = 255;

endpackage

// File: rtl/garo_stage.sv
// One Galois ring stage: an odd inverter chain followed by the feedback XOR.
module garo_stage #(
  parameter int INV_PER_STAGE = 3
) (
  input  logic stage_i,
  input  logic fb_i,
  output logic stage_o
);

  (* keep = "true", dont_touch = "true" *) logic [INV_PER_STAGE:0] inv_chain;

  always_comb begin
    inv_chain[0] = stage_i;
    for (int k = 0; k < INV_PER_STAGE; k++) begin
      inv_chain[k+1] = ~inv_chain[k];
    end
  end

  assign stage_o = inv_chain[INV_PER_STAGE] ^ fb_i;

endmodule

// File: rtl/garo_trng_core.sv
// Galois ring oscillator TRNG: ring, raw-bit synchroniser, decimation,
// von Neumann correction, repetition-count health test and word output.
module garo_trng_core
  import garo_trng_core_pkg::*;
#(
  parameter int                  N_STAGES      = 15,
  parameter int                  INV_PER_STAGE = 3,
  parameter logic [N_STAGES-1:0] POLY          = 15'h4E2B,
  parameter int                  DECIM         = 8,
  parameter int                  WIDTH         = 32,
  parameter int                  WARMUP_CYC    = 256,
  parameter int                  RCT_LIMIT     = 31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             test_mode,
  input  logic             test_bit,
  output logic [WIDTH-1:0] rnd_data,
  output logic             rnd_valid,
  input  logic             rnd_ready,
  output logic             health_fail,
  output logic             busy
);

  localparam int WW = $clog2(WARMUP_CYC + 1);
  localparam int BW = $clog2(WIDTH + 1);
  localparam logic [7:0]    DEC_LAST  = 8'(DECIM - 1);
  localparam logic [7:0]    RCT_MAX   = 8'(RCT_LIMIT);
  localparam logic [WW-1:0] WARM_LAST = WW'(WARMUP_CYC - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH - 1);

  if (N_STAGES < 3 || N_STAGES > MAX_STAGES || (N_STAGES % 2) == 0) begin : g_bad_stages
    $error("garo_trng_core: N_STAGES must be odd and within 3..MAX_STAGES");
  end
  if (RCT_LIMIT < 2 || RCT_LIMIT > MAX_RCT_LIMIT) begin : g_bad_rct
    $error("garo_trng_core: RCT_LIMIT must be within 2..MAX_RCT_LIMIT");
  end

  logic                ring_q;
  logic [N_STAGES-1:0] taps;
  logic [1:0]          sync_q;
  logic [1:0]          rst_sync_q;
  logic                run_ok;

  // The loop closes through ring_q, so the inverter chains form a long
  // sampled path instead of a combinational cycle; enable low freezes it.
  for (genvar i = 0; i < N_STAGES; i++) begin : g_ring
    (* keep = "true", dont_touch = "true" *) logic stage_in;
    (* keep = "true", dont_touch = "true" *) logic stage_out;
    logic fb;
    if (i == 0) begin : g_head
      assign stage_in = ring_q;
    end else begin : g_link
      assign stage_in = g_ring[i-1].stage_out;
    end
    assign fb = POLY[i] & ring_q & enable;
    garo_stage #(.INV_PER_STAGE(INV_PER_STAGE)) u_stage (
      .stage_i (stage_in),
      .fb_i    (fb),
      .stage_o (stage_out)
    );
    assign taps[i] = stage_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ring_q     <= 1'b0;
      sync_q     <= 2'b00;
      rst_sync_q <= 2'b00;
    end else begin
      ring_q     <= enable & taps[N_STAGES-1];
      sync_q     <= {sync_q[0], ^taps};
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run_ok = rst_sync_q[1];

  garo_state_e      state_q;
  logic             busy_q, fail_q;
  logic [WW-1:0]    warm_q;
  logic [7:0]       dec_q;
  logic             pair_q, first_q;
  logic [BW-1:0]    bit_cnt_q;
  logic [WIDTH-2:0] shift_q;
  logic [7:0]       rct_q;
  logic             prev_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;

  logic             raw_bit, strobe, emit, word_done;
  logic [WIDTH-1:0] word_d;
  logic [7:0]       rct_d;

  assign raw_bit   = test_mode ? test_bit : sync_q[1];
  assign strobe    = enable && (state_q == ST_RUN) && (dec_q == DEC_LAST);
  assign emit      = strobe && pair_q && (first_q != raw_bit);
  assign word_done = emit && (bit_cnt_q == BIT_LAST);
  assign word_d    = {shift_q, first_q};

  always_comb begin
    rct_d = 8'd1;
    if (rct_q != 8'd0 && raw_bit == prev_q) begin
      rct_d = (rct_q == RCT_MAX) ? rct_q : rct_q + 8'd1;
    end
  end

  // The output handshake runs in every state so a pending word always drains.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      fail_q    <= 1'b0;
      warm_q    <= '0;
      dec_q     <= '0;
      pair_q    <= 1'b0;
      first_q   <= 1'b0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rct_q     <= '0;
      prev_q    <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      if (word_done && (!valid_q || rnd_ready)) begin
        data_q  <= word_d;
        valid_q <= 1'b1;
      end else if (valid_q && rnd_ready) begin
        valid_q <= 1'b0;
      end

      if (!enable) begin
        state_q   <= ST_IDLE;
        busy_q    <= 1'b0;
        dec_q     <= '0;
        pair_q    <= 1'b0;
        bit_cnt_q <= '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (run_ok) begin
              state_q   <= ST_WARMUP;
              busy_q    <= 1'b1;
              fail_q    <= 1'b0;
              warm_q    <= '0;
              dec_q     <= '0;
              pair_q    <= 1'b0;
              bit_cnt_q <= '0;
              rct_q     <= '0;
              prev_q    <= 1'b0;
            end
          end
          ST_WARMUP: begin
            if (warm_q == WARM_LAST) begin
              state_q <= ST_RUN;
            end else begin
              warm_q <= warm_q + WW'(1);
            end
          end
          ST_RUN: begin
            if (strobe) begin
              dec_q  <= '0;
              prev_q <= raw_bit;
              rct_q  <= rct_d;
              pair_q <= ~pair_q;
              if (!pair_q) begin
                first_q <= raw_bit;
              end
              if (emit) begin
                shift_q   <= word_d[WIDTH-2:0];
                bit_cnt_q <= word_done ? '0 : bit_cnt_q + BW'(1);
              end
              if (rct_d == RCT_MAX) begin
                state_q <= ST_FAIL;
                busy_q  <= 1'b0;
                fail_q  <= 1'b1;
              end
            end else begin
              dec_q <= dec_q + 8'd1;
            end
          end
          ST_FAIL: begin
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rnd_data    = data_q;
  assign rnd_valid   = valid_q;
  assign health_fail = fail_q;
  assign busy        = busy_q;

endmodule
